// File: rtl/fetch_sequencer.sv
// -----------------------------------------------------------------------------
// fetch_sequencer
//   Instruction-fetch sequencer for a small accumulator-style CPU. Holds the
//   program counter, the instruction register and a 3-bit phase counter that
//   the external controller decodes. A two-state machine (RUN / HALTED) stops
//   the phase counter and freezes PC/IR when the controller asks for a halt.
//   A single-cycle go pulse restarts the machine.
//
// Ports
//   clk      in   single clock, rising edge
//   rst      in   synchronous active-high reset (overrides everything)
//   data_in  in   memory data bus, instruction word = {opcode, address}
//   ld_ir    in   load IR from data_in
//   inc_pc   in   increment PC (modulo 2^ADDR_WIDTH)
//   ld_pc    in   load PC from IR address field (wins over inc_pc)
//   halt     in   enter HALTED
//   sel      in   1: PC drives addr, 0: IR address drives addr
//   go       in   restart request, honoured only while HALTED
//   phase    out  instruction-cycle phase 0..7
//   opcode   out  IR opcode field
//   ir_addr  out  IR address field
//   pc       out  program counter
//   addr     out  memory address (combinational mux)
//   halted   out  1 while in HALTED
// -----------------------------------------------------------------------------
module fetch_sequencer #(
  parameter int OPCODE_WIDTH = 3,
  parameter int ADDR_WIDTH   = 5,
  parameter int DATA_WIDTH   = OPCODE_WIDTH + ADDR_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [DATA_WIDTH-1:0]   data_in,
  input  logic                    ld_ir,
  input  logic                    inc_pc,
  input  logic                    ld_pc,
  input  logic                    halt,
  input  logic                    sel,
  input  logic                    go,
  output logic [2:0]              phase,
  output logic [OPCODE_WIDTH-1:0] opcode,
  output logic [ADDR_WIDTH-1:0]   ir_addr,
  output logic [ADDR_WIDTH-1:0]   pc,
  output logic [ADDR_WIDTH-1:0]   addr,
  output logic                    halted
);

  typedef enum logic [0:0] {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } state_e;

  state_e                  state_q, state_d;
  logic [2:0]              phase_q, phase_d;
  logic [ADDR_WIDTH-1:0]   pc_q, pc_d;
  logic [DATA_WIDTH-1:0]   ir_q, ir_d;

  // Field views of the current instruction word.
  logic [OPCODE_WIDTH-1:0] ir_opcode_s;
  logic [ADDR_WIDTH-1:0]   ir_addr_s;

  assign ir_opcode_s = ir_q[DATA_WIDTH-1 -: OPCODE_WIDTH];
  assign ir_addr_s   = ir_q[ADDR_WIDTH-1:0];

  // State, phase, PC and IR registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RUN;
      phase_q <= 3'd0;
      pc_q    <= {ADDR_WIDTH{1'b0}};
      ir_q    <= {DATA_WIDTH{1'b0}};
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
    end
  end

  // Next-state logic: strobes act only in RUN; go acts only in HALTED.
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    case (state_q)
      ST_RUN: begin
        if (ld_ir) begin
          ir_d = data_in;
        end else begin
          ir_d = ir_q;
        end
        // PC loads from the IR as it stands before this edge, so a
        // simultaneous ld_ir does not feed through to the new PC.
        if (ld_pc) begin
          pc_d = ir_addr_s;
        end else if (inc_pc) begin
          pc_d = pc_q + ADDR_WIDTH'(1);
        end else begin
          pc_d = pc_q;
        end
        // The halting edge still honours the strobes but freezes phase.
        if (halt) begin
          state_d = ST_HALTED;
          phase_d = phase_q;
        end else begin
          state_d = ST_RUN;
          phase_d = phase_q + 3'd1;
        end
      end
      ST_HALTED: begin
        if (go) begin
          state_d = ST_RUN;
          phase_d = phase_q + 3'd1;
        end else begin
          state_d = ST_HALTED;
          phase_d = phase_q;
        end
      end
      default: begin
        state_d = ST_RUN;
        phase_d = 3'd0;
      end
    endcase
  end

  assign phase   = phase_q;
  assign opcode  = ir_opcode_s;
  assign ir_addr = ir_addr_s;
  assign pc      = pc_q;
  assign addr    = sel ? pc_q : ir_addr_s;
  assign halted  = (state_q == ST_HALTED);

endmodule
